uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and issue controller placed directly upstream of the UART transmitter, in the TX clock domain. A host writes bytes at arbitrary rate; the block stores them in a circular FIFO and hands them one at a time to the transmitter via the `TX_IN_P`/`TX_IN_V` load interface, issuing the next byte only after the transmitter's busy indication (`TX_OUT_V`) has risen and fallen. It removes the need for the host to poll transmitter status between bytes.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2. `ADDR_W` = log2(`DEPTH`) is derived, not overridable.
- `BUSY_WAIT`, 4: cycles after a load pulse to wait for `TX_BUSY` to rise before abandoning the wait; ≥ 1.

Ports:
- `CLK`  in  1  single clock; same clock as the UART transmitter (`TX_CLK`).
- `RST`  in  1  synchronous, active-high reset.
- `WR_DATA`  in  8  byte to enqueue.
- `WR_EN`  in  1  write strobe, sampled each rising edge.
- `CLR_OVF`  in  1  clears `OVERFLOW`.
- `TX_BUSY`  in  1  transmitter busy; connected to the UART `TX_OUT_V`.
- `TX_IN_P`  out  8  byte presented to the transmitter.
- `TX_IN_V`  out  1  one-cycle load pulse to the transmitter.
- `FULL`  out  1  `COUNT` == `DEPTH`.
- `EMPTY`  out  1  `COUNT` == 0.
- `COUNT`  out  `ADDR_W`+1  stored entries, range 0..`DEPTH`.
- `OVERFLOW`  out  1  sticky; a write was dropped.

## Operation
- Storage: `DEPTH` x 8 array; `wr_ptr` and `rd_ptr` are `ADDR_W` bits and wrap modulo `DEPTH`. `COUNT` is tracked explicitly. `FULL` and `EMPTY` are combinational decodes of the registered `COUNT`.
- Write: if `WR_EN` and !`FULL` at an edge, store `WR_DATA` at `wr_ptr`, increment `wr_ptr`, and increment `COUNT`. If `WR_EN` and `FULL`, the data is dropped and `OVERFLOW` is set. A pop in the same cycle does not make room; the write is still dropped.
- `OVERFLOW`: set on a dropped write; cleared by `CLR_OVF`. If both happen on the same edge, set wins.
- FSM states and transitions:
  - IDLE: if !`EMPTY` and !`TX_BUSY`, go to LOAD.
  - LOAD: lasts exactly one cycle.
    - `TX_IN_V` = 1.
    - `TX_IN_P` is registered from `mem[rd_ptr]` on entry.
    - On the edge that leaves LOAD, increment `rd_ptr` and decrement `COUNT`.
    - Next state: WAIT_START.
  - WAIT_START: if `TX_BUSY` = 1, go to WAIT_DONE. After `BUSY_WAIT` cycles without `TX_BUSY`, return to IDLE. The byte counts as issued and is not retried.
  - WAIT_DONE: when `TX_BUSY` = 0, go to IDLE.
- Simultaneous write and pop: `COUNT` is unchanged; both pointers advance.
- Writing to an empty FIFO gives no fall-through. The byte is issued at the earliest per the Timing rules.
- `TX_IN_P` holds the last loaded byte between loads; it is not cleared when `TX_IN_V` drops.
- The block does not touch parity or prescale configuration; those remain static inputs of the UART.

## Timing
- Reset values, applied on the first rising edge with `RST` = 1:
  - `TX_IN_P` = 8'h00, `TX_IN_V` = 0, `COUNT` = 0.
  - `EMPTY` = 1, `FULL` = 0, `OVERFLOW` = 0.
  - Pointers = 0, FSM = IDLE.
- Reset mid-operation: contents are discarded and `TX_IN_V` is 0 after the reset edge, even if it occurs during LOAD. `WR_EN` is ignored while `RST` = 1.
- Write latency, for a write accepted at edge n into an empty FIFO with `TX_BUSY` = 0:
  - `COUNT` = 1 after edge n.
  - FSM enters LOAD at edge n+1, so `TX_IN_V` is high from edge n+1 to edge n+2.
  - `COUNT` = 0 after edge n+2.
- Back-to-back bytes: the next LOAD occurs no earlier than one edge after `TX_BUSY` is sampled low in WAIT_DONE. IDLE then re-checks `TX_BUSY`, giving a minimum 2-cycle gap between the fall of `TX_BUSY` and the next `TX_IN_V`.
- `TX_IN_V` is never high for two consecutive cycles.
- Full write throughput is 1 byte/cycle until `FULL`.

## Test plan
- Reset check: hold `RST` 2 cycles, then release -> all outputs at the stated reset values, `EMPTY` = 1.
- Single byte: write 8'hA5 with `TX_BUSY` = 0; busy model raises `TX_BUSY` 1 cycle after the pulse and holds it 80 cycles -> `TX_IN_V` exactly 1 cycle, 2 edges after the write; `TX_IN_P` = 8'hA5; `COUNT` back to 0.
- Burst ordering: write 8'h55, 8'hFF, 8'h00, 8'h3C on consecutive cycles with a realistic busy model -> four `TX_IN_V` pulses in that order; no pulse while `TX_BUSY` = 1; each pulse ≥ 2 cycles after the preceding busy fall.
- Full/overflow: hold `TX_BUSY` = 1 and write `DEPTH`+1 bytes -> `FULL` = 1 and `COUNT` = 16 after 16 writes; the 17th write is dropped and `OVERFLOW` = 1; pulse `CLR_OVF` -> `OVERFLOW` = 0. Release busy -> 16 bytes issued in order, with pointer wrap exercised.
- Busy timeout: `TX_BUSY` held 0 after a load -> after `BUSY_WAIT` = 4 cycles the FSM returns to IDLE and the next queued byte loads; no byte is repeated.
- Reset mid-stream: assert `RST` on the LOAD cycle with 3 bytes queued -> `TX_IN_V` = 0 next cycle, `COUNT` = 0, no further loads.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter load port.
// Issues one byte per busy rise/fall handshake of the transmitter.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int BUSY_WAIT = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        WR_DATA,
    input  logic              WR_EN,
    input  logic              CLR_OVF,
    input  logic              TX_BUSY,
    output logic [7:0]        TX_IN_P,
    output logic              TX_IN_V,
    output logic              FULL,
    output logic              EMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW
);

    localparam int WAIT_W = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [7:0]          data_q, data_d;
    logic                ovf_q, ovf_d;
    logic                push;
    logic                pop;

    assign FULL     = (count_q == (ADDR_W + 1)'(DEPTH));
    assign EMPTY    = (count_q == '0);
    assign COUNT    = count_q;
    assign TX_IN_P  = data_q;
    assign TX_IN_V  = (state_q == LOAD);
    assign OVERFLOW = ovf_q;

    // A pop never frees room for a write on the same edge.
    assign push = WR_EN && !FULL;
    assign pop  = (state_q == LOAD);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (!EMPTY && !TX_BUSY) begin
                    state_d = LOAD;
                    data_d  = mem_q[rd_ptr_q];
                end
            end
            LOAD: begin
                state_d = WAIT_START;
                wait_d  = '0;
            end
            WAIT_START: begin
                if (TX_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (wait_q == WAIT_W'(BUSY_WAIT - 1)) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        // A dropped write takes priority over the clear.
        if (WR_EN && FULL) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[wr_ptr_q] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            data_q   <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter busy model.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       clr_ovf;
    logic       tx_busy;
    logic [7:0] tx_in_p;
    logic       tx_in_v;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       ovf;

    logic       auto_en;
    logic       busy_man;
    logic       busy_m;
    int         busy_len;
    int         bcnt;
    logic       mv_prev;

    int         n_chk;
    int         n_pass;
    int         cyc;
    int         last_fall;
    int         viol;
    logic       v_prev;
    logic       bm_prev;
    logic [7:0] pq[$];
    int         pc[$];

    uart_tx_fifo #(
        .DEPTH(16),
        .BUSY_WAIT(4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .WR_DATA(wr_data),
        .WR_EN(wr_en),
        .CLR_OVF(clr_ovf),
        .TX_BUSY(tx_busy),
        .TX_IN_P(tx_in_p),
        .TX_IN_V(tx_in_v),
        .FULL(full),
        .EMPTY(empty),
        .COUNT(count),
        .OVERFLOW(ovf)
    );

    assign tx_busy = auto_en ? busy_m : busy_man;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter model: busy rises one cycle after the load pulse.
    initial begin
        bcnt    = 0;
        busy_m  = 1'b0;
        mv_prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bcnt > 0) bcnt = bcnt - 1;
            if (mv_prev && auto_en) bcnt = busy_len;
            mv_prev = tx_in_v;
            busy_m  = (bcnt != 0);
        end
    end

    initial begin
        cyc       = 0;
        last_fall = -100;
        viol      = 0;
        v_prev    = 1'b0;
        bm_prev   = 1'b0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bm_prev && !busy_m) last_fall = cyc;
        bm_prev = busy_m;
        if (tx_in_v === 1'b1) begin
            pq.push_back(tx_in_p);
            pc.push_back(cyc);
            if (v_prev) viol = viol + 1;
            if (tx_busy) viol = viol + 1;
            if (cyc - last_fall < 2) viol = viol + 1;
        end
        v_prev = tx_in_v;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_chk++;
        if (tx_in_v !== 1'b0) $display("FAIL rst_v got %b want 0", tx_in_v);
        else n_pass++;
        n_chk++;
        if (tx_in_p !== 8'h00) $display("FAIL rst_p got %h want 00", tx_in_p);
        else n_pass++;
        n_chk++;
        if (count !== 5'd0) $display("FAIL rst_count got %0d want 0", count);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++;
        if (empty !== 1'b1) $display("FAIL rst_empty got %b want 1", empty);
        else n_pass++;
        n_chk++;
        if (full !== 1'b0) $display("FAIL rst_full got %b want 0", full);
        else n_pass++;
        n_chk++;
        if (ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", ovf);
        else n_pass++;
        n_chk++;
        if (tx_in_v !== 1'b0) $display("FAIL rel_v got %b want 0", tx_in_v);
        else n_pass++;
    endtask

    task automatic test_single();
        int i;
        pq.delete();
        auto_en  = 1'b1;
        busy_len = 80;
        wr_en    = 1'b1;
        wr_data  = 8'hA5;
        tick();
        wr_en = 1'b0;
        n_chk++;
        if (count !== 5'd1) $display("FAIL single_cnt1 got %0d want 1", count);
        else n_pass++;
        n_chk++;
        if (tx_in_v !== 1'b0) $display("FAIL single_v0 got %b want 0", tx_in_v);
        else n_pass++;
        tick();
        n_chk++;
        if (tx_in_v !== 1'b1) $display("FAIL single_v1 got %b want 1", tx_in_v);
        else n_pass++;
        n_chk++;
        if (tx_in_p !== 8'hA5) $display("FAIL single_p got %h want a5", tx_in_p);
        else n_pass++;
        tick();
        n_chk++;
        if (tx_in_v !== 1'b0) $display("FAIL single_v2 got %b want 0", tx_in_v);
        else n_pass++;
        n_chk++;
        if (count !== 5'd0) $display("FAIL single_cnt0 got %0d want 0", count);
        else n_pass++;
        n_chk++;
        if (tx_in_p !== 8'hA5) $display("FAIL single_hold got %h want a5", tx_in_p);
        else n_pass++;
        for (i = 0; i < 200 && tx_busy !== 1'b0; i++) tick();
        repeat (4) tick();
        n_chk++;
        if (pq.size() !== 1) $display("FAIL single_npulse got %0d want 1", pq.size());
        else n_pass++;
    endtask

    task automatic test_burst();
        logic [7:0] exp [4];
        int i;
        exp[0] = 8'h55;
        exp[1] = 8'hFF;
        exp[2] = 8'h00;
        exp[3] = 8'h3C;
        pq.delete();
        auto_en  = 1'b1;
        busy_len = 6;
        for (int k = 0; k < 4; k++) begin
            wr_en   = 1'b1;
            wr_data = exp[k];
            tick();
        end
        wr_en = 1'b0;
        for (i = 0; i < 500 && !(pq.size() >= 4 && tx_busy === 1'b0); i++) tick();
        repeat (4) tick();
        n_chk++;
        if (pq.size() !== 4) $display("FAIL burst_npulse got %0d want 4", pq.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (k < pq.size()) begin
                n_chk++;
                if (pq[k] !== exp[k]) $display("FAIL burst_data%0d got %h want %h", k, pq[k], exp[k]);
                else n_pass++;
            end
        end
        n_chk++;
        if (viol !== 0) $display("FAIL burst_timing got %0d violations want 0", viol);
        else n_pass++;
    endtask

    task automatic test_full();
        int i;
        auto_en  = 1'b0;
        busy_man = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'h10 + 8'(k);
            tick();
            if (k == 14) begin
                n_chk++;
                if (full !== 1'b0) $display("FAIL full_at15 got %b want 0", full);
                else n_pass++;
            end
        end
        wr_en = 1'b0;
        n_chk++;
        if (full !== 1'b1) $display("FAIL full_flag got %b want 1", full);
        else n_pass++;
        n_chk++;
        if (count !== 5'd16) $display("FAIL full_count got %0d want 16", count);
        else n_pass++;
        n_chk++;
        if (ovf !== 1'b0) $display("FAIL full_ovf0 got %b want 0", ovf);
        else n_pass++;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        n_chk++;
        if (ovf !== 1'b1) $display("FAIL ovf_set got %b want 1", ovf);
        else n_pass++;
        n_chk++;
        if (count !== 5'd16) $display("FAIL ovf_count got %0d want 16", count);
        else n_pass++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_chk++;
        if (ovf !== 1'b0) $display("FAIL ovf_clr got %b want 0", ovf);
        else n_pass++;
        wr_en   = 1'b1;
        clr_ovf = 1'b1;
        tick();
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        n_chk++;
        if (ovf !== 1'b1) $display("FAIL ovf_setwins got %b want 1", ovf);
        else n_pass++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        pq.delete();
        busy_len = 3;
        auto_en  = 1'b1;
        busy_man = 1'b0;
        for (i = 0; i < 800 && !(pq.size() >= 16 && tx_busy === 1'b0); i++) tick();
        repeat (4) tick();
        n_chk++;
        if (pq.size() !== 16) $display("FAIL drain_npulse got %0d want 16", pq.size());
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            if (k < pq.size()) begin
                n_chk++;
                if (pq[k] !== 8'h10 + 8'(k))
                    $display("FAIL drain_data%0d got %h want %h", k, pq[k], 8'h10 + 8'(k));
                else n_pass++;
            end
        end
        n_chk++;
        if (empty !== 1'b1) $display("FAIL drain_empty got %b want 1", empty);
        else n_pass++;
        n_chk++;
        if (viol !== 0) $display("FAIL drain_timing got %0d violations want 0", viol);
        else n_pass++;
    endtask

    task automatic test_timeout();
        pq.delete();
        pc.delete();
        auto_en  = 1'b0;
        busy_man = 1'b0;
        tick();
        wr_en   = 1'b1;
        wr_data = 8'hB1;
        tick();
        wr_data = 8'hB2;
        tick();
        wr_en = 1'b0;
        repeat (30) tick();
        n_chk++;
        if (pq.size() !== 2) $display("FAIL tmo_npulse got %0d want 2", pq.size());
        else n_pass++;
        if (pq.size() >= 2) begin
            n_chk++;
            if (pq[0] !== 8'hB1) $display("FAIL tmo_data0 got %h want b1", pq[0]);
            else n_pass++;
            n_chk++;
            if (pq[1] !== 8'hB2) $display("FAIL tmo_data1 got %h want b2", pq[1]);
            else n_pass++;
            n_chk++;
            if (pc[1] - pc[0] !== 6) $display("FAIL tmo_gap got %0d want 6", pc[1] - pc[0]);
            else n_pass++;
        end
        n_chk++;
        if (empty !== 1'b1) $display("FAIL tmo_empty got %b want 1", empty);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int npre;
        auto_en  = 1'b0;
        busy_man = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'hC1 + 8'(k);
            tick();
        end
        wr_en    = 1'b0;
        busy_man = 1'b0;
        tick();
        n_chk++;
        if (tx_in_v !== 1'b1) $display("FAIL rmid_load got %b want 1", tx_in_v);
        else n_pass++;
        n_chk++;
        if (count !== 5'd3) $display("FAIL rmid_cnt3 got %0d want 3", count);
        else n_pass++;
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hDD;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        npre  = pq.size();
        n_chk++;
        if (tx_in_v !== 1'b0) $display("FAIL rmid_v got %b want 0", tx_in_v);
        else n_pass++;
        n_chk++;
        if (count !== 5'd0) $display("FAIL rmid_cnt got %0d want 0", count);
        else n_pass++;
        n_chk++;
        if (tx_in_p !== 8'h00) $display("FAIL rmid_p got %h want 00", tx_in_p);
        else n_pass++;
        repeat (20) tick();
        n_chk++;
        if (pq.size() !== npre) $display("FAIL rmid_noload got %0d want %0d", pq.size(), npre);
        else n_pass++;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        clr_ovf  = 1'b0;
        busy_man = 1'b0;
        auto_en  = 1'b1;
        busy_len = 4;
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
